// File: rtl/mips_pkg.sv
// Shared types for the multiply/divide unit: operation codes and FSM states.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package mips_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } muldiv_state_t;

  function automatic logic op_is_div(input muldiv_op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/definitions.sv
// Global machine-word definitions shared by the datapath blocks.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

// File: rtl/muldiv_step.sv
// One iteration of the unsigned core: a shift-add multiply step or a
// restoring divide step over the 2*WIDTH accumulator {upper, lower}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] next_acc
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: lower half holds the remaining multiplier bits, upper half the partial product.
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = rem_sh - {1'b0, operand};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        next_acc = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        next_acc = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      next_acc = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// Optional MULDIV_FAST_ZERO_EN: zero-operand multiplies and divide-by-zero finish at the start edge.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = `WORD_SIZE,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  muldiv_state_t      state, state_next;
  muldiv_op_t         op_q;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   opnd;
  logic               neg_res, neg_rem;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  // Operand preparation for a new request
  muldiv_op_t         op_in;
  logic               is_div_in, a_neg, b_neg, b_zero, launch;
  logic [WIDTH-1:0]   a_mag, b_mag, opnd_load;
  logic [2*WIDTH-1:0] acc_load;
  logic               neg_res_load, neg_rem_load;

  always_comb begin
    op_in     = muldiv_op_t'(op);
    is_div_in = op_is_div(op_in);
    a_neg     = op_is_signed(op_in) & src_a[WIDTH-1];
    b_neg     = op_is_signed(op_in) & src_b[WIDTH-1];
    a_mag     = a_neg ? neg_w(src_a) : src_a;
    b_mag     = b_neg ? neg_w(src_b) : src_b;
    b_zero    = (src_b == '0);
    if (!is_div_in) begin
      acc_load     = {{WIDTH{1'b0}}, b_mag};
      opnd_load    = a_mag;
      neg_res_load = a_neg ^ b_neg;
      neg_rem_load = 1'b0;
    end else if (b_zero) begin
      // A zero divisor makes every trial subtract succeed: quotient all ones,
      // remainder equal to the raw dividend, with no sign correction.
      acc_load     = {{WIDTH{1'b0}}, src_a};
      opnd_load    = '0;
      neg_res_load = 1'b0;
      neg_rem_load = 1'b0;
    end else begin
      acc_load     = {{WIDTH{1'b0}}, a_mag};
      opnd_load    = b_mag;
      neg_res_load = a_neg ^ b_neg;
      neg_rem_load = a_neg;
    end
  end

`ifdef MULDIV_FAST_ZERO_EN
  logic fast_zero;
  assign fast_zero = is_div_in ? b_zero : ((src_a == '0) || b_zero);
  assign launch    = start & ~fast_zero;
`else
  assign launch    = start;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_is_div(op_q)),
    .acc      (acc),
    .operand  (opnd),
    .next_acc (acc_next)
  );

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  always_comb begin
    prod   = neg_res ? neg_2w(acc) : acc;
    quo    = neg_res ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem    = neg_rem ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    fix_hi = op_is_div(op_q) ? rem : prod[2*WIDTH-1:WIDTH];
    fix_lo = op_is_div(op_q) ? quo : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= OP_MULT;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (hilo_we) begin
            if (hilo_sel) hi_q <= hilo_wdata;
            else          lo_q <= hilo_wdata;
          end
`ifdef MULDIV_FAST_ZERO_EN
          if (start && fast_zero) begin
            hi_q   <= is_div_in ? src_a : '0;
            lo_q   <= is_div_in ? '1 : '0;
            done_q <= 1'b1;
          end
`endif
          if (launch) begin
            op_q    <= op_in;
            acc     <= acc_load;
            opnd    <= opnd_load;
            neg_res <= neg_res_load;
            neg_rem <= neg_rem_load;
            cnt     <= '0;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH=32): latency, signed/unsigned results,
// divide-by-zero, ignored requests while busy, MTHI/MTLO and asynchronous reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        hilo_we, hilo_sel;
  logic [31:0] hilo_wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .hilo_we    (hilo_we),
    .hilo_sel   (hilo_sel),
    .hilo_wdata (hilo_wdata),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  // Launches one operation in the current cycle (cycle 0) and observes 45 cycles.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int last_busy, output int busy_err, output int first_done,
                       output int n_done, output logic [31:0] hi_d, output logic [31:0] lo_d);
    op = o; src_a = a; src_b = b; start = 1'b1;
    busy_err = 0; first_done = 0; n_done = 0; hi_d = '0; lo_d = '0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      src_a = $urandom;
      src_b = $urandom;
      if (busy !== (c <= last_busy)) busy_err++;
      if (done === 1'b1) begin
        n_done++;
        if (first_done == 0) begin
          first_done = c; hi_d = hi; lo_d = lo;
        end
      end
    end
  endtask

  task automatic test_reset();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
  endtask

  task automatic test_multu_latency();
    int be, fd, nd; logic [31:0] h, l;
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, be, fd, nd, h, l);
    vectors++; if (be !== 0) begin miscompares++; $display("FAIL multu_busy_window: %0d bad cycles, expected 0", be); end
    vectors++; if (fd !== 34) begin miscompares++; $display("FAIL multu_done_cycle: got %0d expected 34", fd); end
    vectors++; if (nd !== 1) begin miscompares++; $display("FAIL multu_done_count: got %0d expected 1", nd); end
    vectors++; if (h !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_hi: got %h expected fffffffe", h); end
    vectors++; if (l !== 32'h00000001) begin miscompares++; $display("FAIL multu_lo: got %h expected 00000001", l); end
  endtask

  task automatic test_signed_ops();
    int be, fd, nd; logic [31:0] h, l;
    do_op(2'b00, 32'hFFFFFFFD, 32'd7, 33, be, fd, nd, h, l);
    vectors++; if (h !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_neg_hi: got %h expected ffffffff", h); end
    vectors++; if (l !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL mult_neg_lo: got %h expected ffffffeb", l); end
    do_op(2'b11, 32'd100, 32'd7, 33, be, fd, nd, h, l);
    vectors++; if (l !== 32'd14) begin miscompares++; $display("FAIL divu_lo: got %h expected 0000000e", l); end
    vectors++; if (h !== 32'd2) begin miscompares++; $display("FAIL divu_hi: got %h expected 00000002", h); end
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 33, be, fd, nd, h, l);
    vectors++; if (l !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_neg_lo: got %h expected fffffffd", l); end
    vectors++; if (h !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_neg_hi: got %h expected ffffffff", h); end
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 33, be, fd, nd, h, l);
    vectors++; if (l !== 32'h80000000) begin miscompares++; $display("FAIL div_ovf_lo: got %h expected 80000000", l); end
    vectors++; if (h !== 32'h0) begin miscompares++; $display("FAIL div_ovf_hi: got %h expected 00000000", h); end
    vectors++; if (fd !== 34) begin miscompares++; $display("FAIL div_done_cycle: got %0d expected 34", fd); end
  endtask

  task automatic test_div_by_zero();
    int be, fd, nd, exp_fd, exp_last; logic [31:0] h, l;
`ifdef MULDIV_FAST_ZERO_EN
    exp_fd = 1; exp_last = 0;
`else
    exp_fd = 34; exp_last = 33;
`endif
    do_op(2'b11, 32'd5, 32'd0, exp_last, be, fd, nd, h, l);
    vectors++; if (be !== 0) begin miscompares++; $display("FAIL div0_busy: %0d bad cycles, expected 0", be); end
    vectors++; if (fd !== exp_fd) begin miscompares++; $display("FAIL div0_done_cycle: got %0d expected %0d", fd, exp_fd); end
    vectors++; if (h !== 32'd5) begin miscompares++; $display("FAIL div0_hi: got %h expected 00000005", h); end
    vectors++; if (l !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div0_lo: got %h expected ffffffff", l); end
  endtask

  // Preceded by test_div_by_zero, so LO holds ffffffff when this starts.
  task automatic test_back_to_back();
    int fd = 0, nd = 0; logic [31:0] h = '0, l = '0, lo6 = '0;
    op = 2'b01; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (c == 5) begin
        start = 1'b1; op = 2'b11; src_a = 32'd9; src_b = 32'd3;
        hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h0000AAAA;
      end else begin
        start = 1'b0; hilo_we = 1'b0;
      end
      if (c == 6) lo6 = lo;
      if (done === 1'b1) begin
        nd++;
        if (fd == 0) begin fd = c; h = hi; l = lo; end
      end
    end
    vectors++; if (lo6 !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL busy_mtlo_ignored: got %h expected ffffffff", lo6); end
    vectors++; if (nd !== 1) begin miscompares++; $display("FAIL b2b_done_count: got %0d expected 1", nd); end
    vectors++; if (fd !== 34) begin miscompares++; $display("FAIL b2b_done_cycle: got %0d expected 34", fd); end
    vectors++; if (h !== 32'h0) begin miscompares++; $display("FAIL b2b_hi: got %h expected 00000000", h); end
    vectors++; if (l !== 32'd6) begin miscompares++; $display("FAIL b2b_lo: got %h expected 00000006", l); end
  endtask

  task automatic test_hilo_with_start();
    logic [31:0] lo1 = '0, h = '0, l = '0;
    op = 2'b01; src_a = 32'd4; src_b = 32'd5; start = 1'b1;
    hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h0000AAAA;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start = 1'b0; hilo_we = 1'b0;
      if (c == 1) lo1 = lo;
      if (done === 1'b1) begin h = hi; l = lo; end
    end
    vectors++; if (lo1 !== 32'h0000AAAA) begin miscompares++; $display("FAIL idle_mtlo_with_start: got %h expected 0000aaaa", lo1); end
    vectors++; if (h !== 32'h0) begin miscompares++; $display("FAIL mtlo_start_hi: got %h expected 00000000", h); end
    vectors++; if (l !== 32'd20) begin miscompares++; $display("FAIL mtlo_start_lo: got %h expected 00000014", l); end
  endtask

  task automatic test_reset_mid_run();
    int done_seen = 0;
    op = 2'b00; src_a = 32'd5; src_b = 32'hFFFFFFFB; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrun_reset_busy: got %b expected 0", busy); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL midrun_reset_hi: got %h expected 00000000", hi); end
    vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL midrun_reset_lo: got %h expected 00000000", lo); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midrun_reset_done: got %b expected 0", done); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h00001234;
    @(posedge clk); #1;
    if (done === 1'b1) done_seen++;
    hilo_sel = 1'b0; hilo_wdata = 32'h00005678;
    @(posedge clk); #1;
    hilo_we = 1'b0;
    if (done === 1'b1) done_seen++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    vectors++; if (hi !== 32'h00001234) begin miscompares++; $display("FAIL mthi: got %h expected 00001234", hi); end
    vectors++; if (lo !== 32'h00005678) begin miscompares++; $display("FAIL mtlo: got %h expected 00005678", lo); end
    vectors++; if (done_seen !== 0) begin miscompares++; $display("FAIL mt_no_done: %0d cycles with done/busy, expected 0", done_seen); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    test_multu_latency();
    test_signed_ops();
    test_div_by_zero();
    test_back_to_back();
    test_hilo_with_start();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
